bakraid_sound_mailbox: RTL
==========================

Name: bakraid_sound_mailbox

Overview:
- Bidirectional command mailbox between the 68K main CPU and the Z80 sound CPU; the Z80 sound CPU is the consumer of this block's commands.
- Provides four 8-bit latches:
  - latches 0 and 1 carry commands 68K -> Z80 (SOUNDLATCH, SOUNDLATCH2);
  - latches 2 and 3 carry replies Z80 -> 68K (SOUNDLATCH3, SOUNDLATCH4).
- Each latch has a full flag and a sticky overrun flag.
- Generates a timed NMI pulse to the Z80 whenever a command arrives in latch 0.

Parameters:
- NMI_LEN, 8, NMI pulse length counted in Z80_CEN ticks (1..15).
- CW, 4, width of the NMI counter.

Ports:
- CLK  in  1  system clock (48 MHz domain).
- RESET_N  in  1  asynchronous, active-low reset.
- Z80_CEN  in  1  Z80 clock enable; timebase for the NMI pulse.
- M_WR  in  1  68K write strobe, one CLK cycle per access.
- M_RD  in  1  68K read strobe, one CLK cycle per access.
- M_ADDR  in  2  68K latch select.
- M_DIN  in  8  68K write data.
- M_DOUT  out  8  68K read data, registered.
- Z_WR  in  1  Z80 write strobe, one CLK cycle per access.
- Z_RD  in  1  Z80 read strobe, one CLK cycle per access.
- Z_ADDR  in  2  Z80 latch select.
- Z_DIN  in  8  Z80 write data.
- Z_DOUT  out  8  Z80 read data, registered.
- NMI  out  1  Z80 NMI, active high.
- LATCH_FULL  out  4  full flags, bit i corresponds to latch i.

Behaviour:
- Clocking and reset:
  - Single clock CLK; reset is RESET_N, asynchronous and active-low.
  - On reset: all latches = 8'h00, full = 0, overrun = 0, M_DOUT = Z_DOUT = 8'h00, NMI = 0, NMI counter = 0.
  - Asserting reset mid-pulse or mid-access aborts it immediately.
  - No strobe is honoured while RESET_N is low.
- 68K write (M_WR):
  - Addresses 0 and 1: latch[addr] <= M_DIN; full[addr] <= 1.
  - If full[addr] was already 1 and no same-cycle consumer read occurs, overrun[addr] <= 1.
  - Addresses 2 and 3: ignored.
- Z80 write (Z_WR): mirror of the 68K write for addresses 2 and 3; addresses 0 and 1 are ignored.
- 68K read (M_RD), one-cycle latency (M_DOUT updates on the edge after the strobe):
  - Addresses 2 and 3: returns latch[addr] and clears full[addr].
  - Addresses 0 and 1: returns status {overrun[3:0], full[3:0]}.
  - A status read clears overrun[1:0] (the flags for the 68K's own producer latches).
- Z80 read (Z_RD), one-cycle latency:
  - Addresses 0 and 1: returns latch[addr] and clears full[addr].
  - Addresses 2 and 3: returns status; a status read clears overrun[3:2].
- Idle outputs: M_DOUT and Z_DOUT hold their last value when not being read.
- LATCH_FULL = full, combinational from the flag registers.
- Same-cycle write and read of the same latch:
  - the read returns the old value;
  - the latch takes the new value;
  - full ends at 1 (write wins);
  - overrun is not set.
- Simultaneous M and Z accesses to different latches proceed independently.
- A status read coincident with a write that sets overrun: the set wins.
- NMI state machine, states IDLE and PULSE:
  - IDLE -> PULSE on a 68K write to address 0. The counter loads NMI_LEN and NMI = 1 on the next cycle.
  - In PULSE, the counter decrements on each Z80_CEN. When it reaches 0, the block returns to IDLE and NMI = 0 on the following cycle.
  - A latch-0 write while in PULSE reloads the counter (retrigger), so NMI stays high continuously.
  - A write to latch 1 never triggers NMI.
  - Counter arithmetic is unsigned CW-bit; NMI_LEN = 0 is illegal (elaboration assertion).
- Out-of-range or simultaneous M_WR and M_RD on the same port in the same cycle: both are performed as specified above; the read sees the pre-write state.

Decomposition:
- Shared package bakraid_snd_pkg holds:
  - latch index constants (LATCH_CMD0 = 0, LATCH_CMD1 = 1, LATCH_RPY0 = 2, LATCH_RPY1 = 3);
  - the status byte layout;
  - the NMI state enum {IDLE, PULSE}.
- One sub-module, bakraid_nmi_pulse: a retriggerable pulse generator with inputs trigger and cen, and output pulse.
- The latch and flag logic stays in the top module.

Test Plan:
- Reset, then M_WR addr0 = 8'h5A:
  - NMI rises the next cycle and stays high for exactly 8 Z80_CEN ticks;
  - LATCH_FULL = 4'b0001;
  - Z_RD addr0 returns 8'h5A one cycle later and LATCH_FULL = 4'b0000.
- M_WR addr1 = 8'h11, then M_WR addr1 = 8'h22 with no Z80 read:
  - an M_RD addr0 status read returns 8'h22 (overrun[1] = 1, full[1] = 1);
  - a second status read returns 8'h02.
- Z_WR addr3 = 8'hC3:
  - M_RD addr3 returns 8'hC3;
  - full[3] clears;
  - NMI stays 0 throughout.
- M_WR addr0 = 8'h01 and Z_RD addr0 in the same cycle, latch previously holding 8'h77 and full:
  - Z_DOUT = 8'h77;
  - latch = 8'h01 with full = 1;
  - no overrun is set.
- Retrigger: M_WR addr0 at Z80_CEN tick 5 of a pulse. NMI stays high for 8 ticks after the second write, 13 ticks total, with no low glitch.
- Drop RESET_N at tick 3 of an NMI pulse with full = 4'b1111: NMI, full, overrun, M_DOUT and Z_DOUT all go to 0 asynchronously, before the next CLK edge.

Source files
------------

// File: rtl/bakraid_snd_pkg.sv
// rtl/bakraid_snd_pkg.sv - shared definitions for the Bakraid sound mailbox
//
// Purpose: latch index map, status byte layout and NMI state encoding shared
// by the mailbox top and its NMI pulse generator.
// Ports: none (package).

package bakraid_snd_pkg;

  // Latches 0/1 carry 68K -> Z80 commands, 2/3 carry Z80 -> 68K replies.
  localparam int LATCH_CMD0 = 0;
  localparam int LATCH_CMD1 = 1;
  localparam int LATCH_RPY0 = 2;
  localparam int LATCH_RPY1 = 3;

  // Status byte returned by a read of the reader's own producer addresses.
  typedef struct packed {
    logic [3:0] overrun;
    logic [3:0] full;
  } status_t;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } nmi_state_t;

  function automatic logic [7:0] pack_status(input logic [3:0] overrun,
                                             input logic [3:0] full);
    status_t s;
    s.overrun = overrun;
    s.full    = full;
    return s;
  endfunction

endpackage

// File: rtl/bakraid_nmi_pulse.sv
// rtl/bakraid_nmi_pulse.sv - retriggerable NMI pulse generator
//
// Purpose: raises pulse the cycle after trigger and holds it for NMI_LEN cen
// ticks; a trigger during the pulse reloads the count so the pulse never drops.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   trigger  single-cycle start/restart request
//   cen      timebase tick (Z80 clock enable)
//   pulse    output, high while in PULSE

module bakraid_nmi_pulse
  import bakraid_snd_pkg::*;
#(
  parameter int NMI_LEN = 8,
  parameter int CW      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  input  logic cen,
  output logic pulse
);

  localparam logic [CW-1:0] LOAD = CW'(NMI_LEN);

  generate
    if (NMI_LEN < 1 || NMI_LEN > (1 << CW) - 1) begin : g_len_check
      $error("bakraid_nmi_pulse: NMI_LEN must be 1..2**CW-1");
    end
  endgenerate

  nmi_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] cnt_dec;

  assign cnt_dec = cnt - CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_nxt = PULSE;
          cnt_nxt   = LOAD;
        end
      end
      PULSE: begin
        // A retrigger takes priority over a coincident tick.
        if (trigger) begin
          cnt_nxt = LOAD;
        end else if (cen) begin
          cnt_nxt = cnt_dec;
          if (cnt_dec == '0) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign pulse = (state == PULSE);

endmodule

// File: rtl/bakraid_sound_mailbox.sv
// rtl/bakraid_sound_mailbox.sv - 68K/Z80 four-latch sound command mailbox
//
// Purpose: two command latches (68K -> Z80) and two reply latches
// (Z80 -> 68K), each with full and sticky overrun flags, plus an NMI pulse to
// the Z80 on every command written to latch 0.
// Ports:
//   CLK, RESET_N        clock, asynchronous active-low reset
//   Z80_CEN             Z80 clock enable, NMI timebase
//   M_WR, M_RD, M_ADDR  68K strobes and latch select; M_DIN / M_DOUT data
//   Z_WR, Z_RD, Z_ADDR  Z80 strobes and latch select; Z_DIN / Z_DOUT data
//   NMI                 Z80 NMI, active high
//   LATCH_FULL          full flag per latch

module bakraid_sound_mailbox
  import bakraid_snd_pkg::*;
#(
  parameter int NMI_LEN = 8,
  parameter int CW      = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       Z80_CEN,
  input  logic       M_WR,
  input  logic       M_RD,
  input  logic [1:0] M_ADDR,
  input  logic [7:0] M_DIN,
  output logic [7:0] M_DOUT,
  input  logic       Z_WR,
  input  logic       Z_RD,
  input  logic [1:0] Z_ADDR,
  input  logic [7:0] Z_DIN,
  output logic [7:0] Z_DOUT,
  output logic       NMI,
  output logic [3:0] LATCH_FULL
);

  logic [7:0] latch [4];
  logic [3:0] full;
  logic [3:0] overrun;

  logic [3:0] wr;        // producer write per latch
  logic [3:0] rd;        // consumer data read per latch
  logic [3:0] ovr_clr;   // status read clearing the reader's own producer flags
  logic [7:0] status;

  assign wr[LATCH_CMD0] = M_WR && (M_ADDR == 2'(LATCH_CMD0));
  assign wr[LATCH_CMD1] = M_WR && (M_ADDR == 2'(LATCH_CMD1));
  assign wr[LATCH_RPY0] = Z_WR && (Z_ADDR == 2'(LATCH_RPY0));
  assign wr[LATCH_RPY1] = Z_WR && (Z_ADDR == 2'(LATCH_RPY1));

  assign rd[LATCH_CMD0] = Z_RD && (Z_ADDR == 2'(LATCH_CMD0));
  assign rd[LATCH_CMD1] = Z_RD && (Z_ADDR == 2'(LATCH_CMD1));
  assign rd[LATCH_RPY0] = M_RD && (M_ADDR == 2'(LATCH_RPY0));
  assign rd[LATCH_RPY1] = M_RD && (M_ADDR == 2'(LATCH_RPY1));

  // Each side reads status at its own producer addresses: 68K at 0/1, Z80 at 2/3.
  assign ovr_clr = {{2{Z_RD && Z_ADDR[1]}}, {2{M_RD && !M_ADDR[1]}}};

  assign status     = pack_status(overrun, full);
  assign LATCH_FULL = full;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4; i++) latch[i] <= 8'h00;
      full    <= 4'b0000;
      overrun <= 4'b0000;
      M_DOUT  <= 8'h00;
      Z_DOUT  <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        // Write wins over a same-cycle consumer read; that read still sees
        // the old contents because every read below uses pre-edge state.
        if (wr[i]) begin
          latch[i] <= (i < 2) ? M_DIN : Z_DIN;
          full[i]  <= 1'b1;
        end else if (rd[i]) begin
          full[i] <= 1'b0;
        end
        // Setting overrun beats a coincident status-read clear.
        if (wr[i] && full[i] && !rd[i]) overrun[i] <= 1'b1;
        else if (ovr_clr[i])            overrun[i] <= 1'b0;
      end
      if (M_RD) M_DOUT <= M_ADDR[1] ? latch[M_ADDR] : status;
      if (Z_RD) Z_DOUT <= Z_ADDR[1] ? status : latch[Z_ADDR];
    end
  end

  bakraid_nmi_pulse #(
    .NMI_LEN (NMI_LEN),
    .CW      (CW)
  ) u_nmi (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .trigger (wr[LATCH_CMD0]),
    .cen     (Z80_CEN),
    .pulse   (NMI)
  );

endmodule
